fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the architectural fetch PC, drives the word address into the combinational instruction ROM, and captures the returned instruction into the IF/ID pipeline register for the decode stage. Applies hazard-unit stalls, decode-stage redirects (branch/jump with one delay slot), and a flush. Flags out-of-range or misaligned fetch addresses.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- IM_BASE, 32'h0000_3000, byte address of ROM word 0
- IM_WORDS, 4096, ROM depth in 32-bit words
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: freeze F_PC and IF/ID
- flush  in  1  replace the next IF/ID contents with a bubble
- redirect_valid  in  1  decode stage: next PC is redirect_target
- redirect_target  in  32  branch/jump target byte address
- im_addr  out  32  byte address to ROM; equals F_PC
- im_instr  in  32  ROM data for im_addr, same cycle
- d_pc  out  32  PC of instruction in IF/ID
- d_instr  out  32  instruction in IF/ID
- d_valid  out  1  IF/ID holds a real fetch, not a bubble
- d_adel  out  1  IF/ID entry came from an illegal fetch address

## Operation
- F_PC register; im_addr = F_PC, combinational.
- Fetch error, combinational: f_adel = (F_PC[1:0] != 0) | (F_PC < IM_BASE) | (F_PC >= IM_BASE + 4*IM_WORDS). Compare in 33 bits so the upper bound cannot wrap.
- Next PC when not stalled: redirect_valid ? redirect_target : F_PC + 4. The add wraps mod 2^32. There is no carry-out.
- IF/ID load when not stalled: d_pc <= F_PC; d_instr <= f_adel ? 32'h0 : im_instr; d_adel <= f_adel; d_valid <= 1.
- stall=1: F_PC and IF/ID hold. redirect_valid is ignored, because decode re-presents it while held.
- flush=1: IF/ID loads a bubble (d_pc <= F_PC, d_instr <= 0, d_valid <= 0, d_adel <= 0). This happens even when stall=1.
- flush does not affect F_PC. F_PC still obeys stall and redirect.
- Delay slot: the instruction fetched in the same cycle as redirect_valid is the delay slot. It enters IF/ID normally and is not squashed.
- A misaligned or out-of-range redirect_target is accepted into F_PC. It is reported through d_adel one cycle later and does not stall.

## Timing
- Reset, synchronous: F_PC = RESET_PC, d_pc = 0, d_instr = 0, d_valid = 0, d_adel = 0. reset overrides stall, flush and redirect.
- Latency: the instruction at F_PC during cycle n is visible on d_* after edge n+1.
- Redirect sampled at edge n: F_PC = target from cycle n+1. Target instruction reaches d_* after edge n+2.
- Reset asserted mid-stall or mid-redirect: the pending state is discarded and fetch restarts at RESET_PC.
- Priority per edge: reset > stall (F_PC) / flush (IF/ID) > redirect > sequential.

## Structure
- Shared package: MIPS_NOP = 32'h0, default RESET_PC/IM_BASE values, and the PC width constant. The decode, hazard and ROM blocks reuse these.
- One sub-module, if_id_reg: the IF/ID register with stall/flush/reset priority. fetch_unit keeps the PC register, next-PC mux and range check.

## Test plan
- Reset, then 4 free-running cycles with ROM holding 0x1111_1111 at 0x3000, 0x2222_2222 at 0x3004, and so on. Required: im_addr 0x3000, 0x3004, 0x3008, 0x300C; d_pc/d_instr trail by one cycle; d_valid rises after the first edge.
- redirect_valid=1, target 0x3100 while F_PC=0x3008. Required: d_pc sequence 0x3008 (delay slot), 0x3100, 0x3104.
- stall=1 for 3 cycles at F_PC=0x300C, with redirect_valid=1 during the stall. Required: im_addr, d_pc and d_instr frozen. After release, F_PC advances per the redirect presented on the first unstalled cycle.
- flush=1 together with stall=1. Required: d_valid=0, d_instr=0, F_PC unchanged. Next cycle without flush/stall: normal fetch resumes.
- Redirect to 0x3002, then to 0x2FFC, then to 0x7000. Required: d_adel=1 and d_instr=0 for each. Redirect to 0x6FFC: d_adel=0.
- Assert reset during a redirect cycle. Required: next im_addr=0x3000, all d_* outputs at their reset values.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: PC width, reset/ROM defaults, the IF/ID
// entry layout and the fetch-address legality check. Decode, hazard and ROM
// blocks import this package as well.
package fetch_unit_pkg;

   localparam int          PC_WIDTH         = 32;
   localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
   localparam int unsigned IM_WORDS_DEFAULT = 4096;

   // One IF/ID pipeline register entry as seen by the decode stage.
   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [31:0]         instr;
      logic                valid;
      logic                adel;
   } if_id_t;

   // True when pc is misaligned or outside [base, base + 4*words).
   // The bounds are formed in 33 bits so a ROM ending at 2^32 cannot wrap.
   function automatic logic fetch_addr_illegal(input logic [PC_WIDTH-1:0] pc,
                                               input logic [PC_WIDTH-1:0] base,
                                               input int unsigned         words);
      logic [PC_WIDTH:0] addr;
      logic [PC_WIDTH:0] lo;
      logic [PC_WIDTH:0] hi;
      addr = {1'b0, pc};
      lo   = {1'b0, base};
      hi   = lo + ({1'b0, words} << 2);
      return (pc[1:0] != 2'b00) | (addr < lo) | (addr >= hi);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's pipeline-control, ROM and IF/ID signals.
// The fetch unit takes the master side; the pipeline/ROM environment the slave.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic                stall;
   logic                flush;
   logic                redirect_valid;
   logic [PC_WIDTH-1:0] redirect_target;
   logic [PC_WIDTH-1:0] im_addr;
   logic [31:0]         im_instr;
   logic [PC_WIDTH-1:0] d_pc;
   logic [31:0]         d_instr;
   logic                d_valid;
   logic                d_adel;

   modport master (
      input  stall, flush, redirect_valid, redirect_target, im_instr,
      output im_addr, d_pc, d_instr, d_valid, d_adel
   );

   modport slave (
      output stall, flush, redirect_valid, redirect_target, im_instr,
      input  im_addr, d_pc, d_instr, d_valid, d_adel
   );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Reset clears it, flush inserts a bubble (even
// while stalled), stall holds it, otherwise it captures the fetched entry.
module if_id_reg
   import fetch_unit_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   stall,
   input  logic   flush,
   input  if_id_t load,
   output if_id_t q
);

   // Register update in priority order: reset, flush bubble, stall hold, load.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (flush) begin
         q.pc    <= load.pc;
         q.instr <= MIPS_NOP;
         q.valid <= 1'b0;
         q.adel  <= 1'b0;
      end else if (!stall) begin
         q <= load;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, addresses the combinational
// instruction ROM, flags illegal fetch addresses and feeds IF/ID.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [PC_WIDTH-1:0] IM_BASE  = IM_BASE_DEFAULT,
   parameter int unsigned         IM_WORDS = IM_WORDS_DEFAULT
)
(
   input logic           clk,
   input logic           reset,
   fetch_unit_if.master  bus
);

   logic [PC_WIDTH-1:0] f_pc;
   logic [PC_WIDTH-1:0] next_pc;
   logic                f_adel;
   if_id_t              fetch_entry;
   if_id_t              if_id_q;

   // Next-PC select: a decode redirect wins over sequential fetch; the +4 wraps.
   always_comb begin
      next_pc = f_pc + 32'd4;
      if (bus.redirect_valid) begin
         next_pc = bus.redirect_target;
      end
   end

   // Fetch PC register; a stall freezes it and drops any redirect on the floor,
   // since decode keeps presenting the redirect until the stall clears.
   always_ff @(posedge clk) begin
      if (reset) begin
         f_pc <= RESET_PC;
      end else if (!stall_q()) begin
         f_pc <= next_pc;
      end
   end

   function automatic logic stall_q();
      return bus.stall;
   endfunction

   // Illegal fetches still advance the pipeline but carry a NOP and the flag.
   always_comb begin
      f_adel            = fetch_addr_illegal(f_pc, IM_BASE, IM_WORDS);
      fetch_entry.pc    = f_pc;
      fetch_entry.instr = f_adel ? MIPS_NOP : bus.im_instr;
      fetch_entry.valid = 1'b1;
      fetch_entry.adel  = f_adel;
   end

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .reset (reset),
      .stall (bus.stall),
      .flush (bus.flush),
      .load  (fetch_entry),
      .q     (if_id_q)
   );

   assign bus.im_addr = f_pc;
   assign bus.d_pc    = if_id_q.pc;
   assign bus.d_instr = if_id_q.instr;
   assign bus.d_valid = if_id_q.valid;
   assign bus.d_adel  = if_id_q.adel;

endmodule
